// File: rtl/pingpong_linebuffer.sv
// rtl/pingpong_linebuffer.sv - double-buffered scanline store with auto-clear of the back bank
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data write into the back bank (accepted only while wr_ready)
//   wr_ready             back bank is in FILL
//   wr_line_done         writer finished the line
//   rd_addr/rd_data      front-bank read, one cycle latency
//   rd_line_start        reader starts a new line, requests a swap
//   line_valid           front bank holds a completed line
//   underrun             swap requested with no completed line available
// Build option: LINEBUF_PRIORITY_EN turns back-bank writes into priority-compare writes.

module pingpong_linebuffer #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DEPTH       = 240,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter int                    PRIO_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  wr_line_done,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_line_start,
    output logic                  line_valid,
    output logic                  underrun
);

    typedef enum logic [1:0] {ST_CLEAR, ST_FILL, ST_DONE, ST_DRAIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    generate
        if (DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
            $error("DEPTH exceeds the address range");
        end
        if (PRIO_WIDTH < 1 || PRIO_WIDTH > DATA_WIDTH) begin : g_bad_prio
            $error("PRIO_WIDTH out of range");
        end
    endgenerate

    state_t                state_q, state_d;
    logic                  front;
    logic                  back;
    logic                  clear_both;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  swap;
    logic                  underrun_d;
    logic                  wr_in_range;

    logic [DATA_WIDTH-1:0] bank0 [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] bank1 [0:DEPTH-1];

    logic [1:0]            clr_we;
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] waddr [2];
    logic [DATA_WIDTH-1:0] wdata [2];

    logic                  usr_we;
    logic                  usr_bank;
    logic [ADDR_WIDTH-1:0] usr_addr;
    logic [DATA_WIDTH-1:0] usr_data;

    assign back        = ~front;
    assign wr_ready    = (state_q == ST_FILL);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);

`ifdef LINEBUF_PRIORITY_EN
    // Two-stage write: stage 0 reads the stored entry, stage 1 compares and commits.
    // The pending write carries its bank so a commit landing after a swap still
    // goes to the line it belongs to.
    logic                  clr0 [0:DEPTH-1];
    logic                  clr1 [0:DEPTH-1];
    logic                  p_valid;
    logic                  p_bank;
    logic                  p_clr;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [DATA_WIDTH-1:0] p_data;
    logic [DATA_WIDTH-1:0] p_stored;
    logic                  win;
    logic                  accept;

    assign accept = (state_q == ST_FILL) && wr_en && wr_in_range;
    assign win    = p_clr || (p_data[DATA_WIDTH-1 -: PRIO_WIDTH] < p_stored[DATA_WIDTH-1 -: PRIO_WIDTH]);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            p_valid <= 1'b0;
        end else begin
            p_valid <= accept;
        end
    end

    always_ff @(posedge clk) begin
        p_addr <= wr_addr;
        p_data <= wr_data;
        p_bank <= back;
        if (p_valid && (p_bank == back) && (p_addr == wr_addr)) begin
            // Forward the pending winner; after its commit the entry is never cleared.
            p_stored <= win ? p_data : p_stored;
            p_clr    <= 1'b0;
        end else begin
            p_stored <= back ? bank1[wr_addr] : bank0[wr_addr];
            p_clr    <= back ? clr1[wr_addr] : clr0[wr_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            if (we[0]) clr0[waddr[0]] <= clr_we[0];
            if (we[1]) clr1[waddr[1]] <= clr_we[1];
        end
    end

    assign usr_we   = p_valid && win;
    assign usr_bank = p_bank;
    assign usr_addr = p_addr;
    assign usr_data = p_data;
`else
    assign usr_we   = (state_q == ST_FILL) && wr_en && wr_in_range;
    assign usr_bank = back;
    assign usr_addr = wr_addr;
    assign usr_data = wr_data;
`endif

    always_comb begin
        state_d    = state_q;
        swap       = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            ST_CLEAR: if (clr_cnt == LAST) state_d = ST_FILL;
`ifdef LINEBUF_PRIORITY_EN
            ST_FILL:  if (wr_line_done) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
`else
            ST_FILL:  if (wr_line_done) state_d = ST_DONE;
`endif
            default:  state_d = state_q;
        endcase
        if (rd_line_start) begin
            // DRAIN already holds a finished line; only its last commit is in flight.
            if (state_q == ST_DONE || state_q == ST_DRAIN ||
                (state_q == ST_FILL && wr_line_done)) begin
                swap    = 1'b1;
                state_d = ST_CLEAR;
            end else begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_CLEAR;
            front      <= 1'b0;
            clear_both <= 1'b1;
            clr_cnt    <= '0;
            line_valid <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q  <= state_d;
            underrun <= underrun_d;
            if (swap) begin
                front      <= back;
                line_valid <= 1'b1;
                clear_both <= 1'b0;
                clr_cnt    <= '0;
            end else begin
                if (rd_line_start) line_valid <= 1'b0;
                if (state_q == ST_CLEAR) begin
                    if (clr_cnt == LAST) begin
                        clear_both <= 1'b0;
                        clr_cnt    <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Clearing owns a bank's write port; user commits never target a bank being cleared.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            clr_we[b] = (state_q == ST_CLEAR) && (clear_both || back == 1'(b));
            we[b]     = clr_we[b] || (usr_we && usr_bank == 1'(b));
            waddr[b]  = clr_we[b] ? clr_cnt : usr_addr;
            wdata[b]  = clr_we[b] ? CLEAR_VALUE : usr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            if (we[0]) bank0[waddr[0]] <= wdata[0];
            if (we[1]) bank1[waddr[1]] <= wdata[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < DEPTH_W) begin
            rd_data <= front ? bank1[rd_addr] : bank0[rd_addr];
        end else begin
            rd_data <= CLEAR_VALUE;
        end
    end

endmodule

// File: tb/tb_pingpong_linebuffer.sv
// tb/tb_pingpong_linebuffer.sv - scoreboard bench for pingpong_linebuffer

module tb_pingpong_linebuffer;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 240;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          wr_line_done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_line_start;
    logic          line_valid;
    logic          underrun;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] m_front [DEPTH];
    logic [DW-1:0] m_back  [DEPTH];

    always #5 clk = ~clk;

    pingpong_linebuffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .CLEAR_VALUE(16'h0000),
        .PRIO_WIDTH (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .wr_line_done (wr_line_done),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_line_start(rd_line_start),
        .line_valid   (line_valid),
        .underrun     (underrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_swap();
        for (int i = 0; i < DEPTH; i++) begin
            m_front[i] = m_back[i];
            m_back[i]  = '0;
        end
    endtask

    task automatic issue_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        rd_addr = a;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic write_word(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!wr_ready && cycles < 1000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        int            cycles;
        logic [DW-1:0] e;
        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_line_done = 1'b0; rd_addr = '0; rd_line_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
        end
        repeat (3) tick();
        n_checks++; if (wr_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
        n_checks++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL reset_line_valid got=%b exp=0", line_valid); end
        n_checks++; if (underrun !== 1'b0)   begin n_fail++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        n_checks++; if (rd_data !== 16'h0)   begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        resetn = 1'b1;
        cycles = 0;
        while (!wr_ready && cycles < 1000) begin
            rd_line_start = (cycles == 10);
            tick();
            cycles++;
            if (cycles == 11) begin
                n_checks++; if (underrun !== 1'b1)   begin n_fail++; $display("FAIL reset_clear_underrun got=%b exp=1", underrun); end
                n_checks++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL reset_clear_line_valid got=%b exp=0", line_valid); end
            end
            if (cycles == 12) begin
                n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_clear_underrun_pulse got=%b exp=0", underrun); end
            end
        end
        rd_line_start = 1'b0;
        n_checks++;
        if (cycles != 240 || wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_clear_len got=%0d cycles ready=%b exp=240 cycles ready=1", cycles, wr_ready);
        end
        for (int i = 0; i < DEPTH; i++) begin
            issue_read(AW'(i), m_front[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e) begin n_fail++; $display("FAIL reset_front_read addr=%0d got=%h exp=%h", i, rd_data, e); end
        end
    endtask

    task automatic test_fill_swap();
        int            cycles;
        logic [DW-1:0] e;
        int            addrs [3] = '{5, 0, 239};
        for (int i = 0; i < DEPTH; i++) begin
            m_back[i] = DW'(16'h100 + i);
            write_word(i, m_back[i]);
        end
        wr_line_done = 1'b1; tick(); wr_line_done = 1'b0;
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL done_wr_ready got=%b exp=0", wr_ready); end
        write_word(0, 16'hDEAD);
        tick();
        rd_line_start = 1'b1; tick(); rd_line_start = 1'b0;
        model_swap();
        n_checks++; if (line_valid !== 1'b1) begin n_fail++; $display("FAIL swap_line_valid got=%b exp=1", line_valid); end
        n_checks++; if (underrun !== 1'b0)   begin n_fail++; $display("FAIL swap_underrun got=%b exp=0", underrun); end
        wait_ready(cycles);
        n_checks++;
        if (cycles != 240 || wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL swap_clear_len got=%0d cycles ready=%b exp=240 cycles ready=1", cycles, wr_ready);
        end
        foreach (addrs[k]) begin
            issue_read(AW'(addrs[k]), m_front[addrs[k]]);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e) begin n_fail++; $display("FAIL swap_read addr=%0d got=%h exp=%h", addrs[k], rd_data, e); end
        end
    endtask

    task automatic test_underrun();
        logic [DW-1:0] e;
        rd_line_start = 1'b1; tick(); rd_line_start = 1'b0;
        n_checks++; if (underrun !== 1'b1)   begin n_fail++; $display("FAIL fill_underrun got=%b exp=1", underrun); end
        n_checks++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL fill_underrun_line_valid got=%b exp=0", line_valid); end
        n_checks++; if (wr_ready !== 1'b1)   begin n_fail++; $display("FAIL fill_underrun_wr_ready got=%b exp=1", wr_ready); end
        tick();
        n_checks++; if (underrun !== 1'b0)   begin n_fail++; $display("FAIL fill_underrun_pulse got=%b exp=0", underrun); end
        issue_read(AW'(5), m_front[5]);
        e = exp_q.pop_front();
        n_checks++; if (rd_data !== e) begin n_fail++; $display("FAIL fill_underrun_front got=%h exp=%h", rd_data, e); end
    endtask

    task automatic test_same_cycle_swap();
        logic [DW-1:0] e;
        for (int i = 0; i < 10; i++) begin
            m_back[i] = DW'(16'h2000 + 3 * i);
            write_word(i, m_back[i]);
        end
        tick();
        wr_line_done = 1'b1; rd_line_start = 1'b1; rd_addr = AW'(3);
        exp_q.push_back(m_front[3]);
        tick();
        wr_line_done = 1'b0; rd_line_start = 1'b0;
        model_swap();
        e = exp_q.pop_front();
        n_checks++; if (rd_data !== e)       begin n_fail++; $display("FAIL same_cycle_old_front got=%h exp=%h", rd_data, e); end
        n_checks++; if (line_valid !== 1'b1) begin n_fail++; $display("FAIL same_cycle_line_valid got=%b exp=1", line_valid); end
        issue_read(AW'(3), m_front[3]);
        e = exp_q.pop_front();
        n_checks++; if (rd_data !== e)       begin n_fail++; $display("FAIL same_cycle_new_front got=%h exp=%h", rd_data, e); end
        rd_line_start = 1'b1; tick(); rd_line_start = 1'b0;
        n_checks++; if (underrun !== 1'b1)   begin n_fail++; $display("FAIL clear_underrun got=%b exp=1", underrun); end
        n_checks++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL clear_underrun_line_valid got=%b exp=0", line_valid); end
        issue_read(AW'(3), m_front[3]);
        e = exp_q.pop_front();
        n_checks++; if (rd_data !== e)       begin n_fail++; $display("FAIL clear_underrun_front got=%h exp=%h", rd_data, e); end
    endtask

    task automatic test_out_of_range();
        int            cycles;
        logic [DW-1:0] e;
        wait_ready(cycles);
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL oor_wait_ready got=%b exp=1 after %0d cycles", wr_ready, cycles); end
        write_word(250, 16'hBEEF);
        write_word(240, 16'h1234);
        m_back[10] = 16'h5555;
        write_word(10, 16'h5555);
        tick();
        wr_line_done = 1'b1; rd_line_start = 1'b1; tick();
        wr_line_done = 1'b0; rd_line_start = 1'b0;
        model_swap();
        issue_read(AW'(250), 16'h0000);
        e = exp_q.pop_front();
        n_checks++; if (rd_data !== e) begin n_fail++; $display("FAIL oor_read250 got=%h exp=%h", rd_data, e); end
        issue_read(AW'(255), 16'h0000);
        e = exp_q.pop_front();
        n_checks++; if (rd_data !== e) begin n_fail++; $display("FAIL oor_read255 got=%h exp=%h", rd_data, e); end
        for (int i = 0; i < DEPTH; i++) begin
            issue_read(AW'(i), m_front[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e) begin n_fail++; $display("FAIL oor_line addr=%0d got=%h exp=%h", i, rd_data, e); end
        end
    endtask

`ifdef LINEBUF_PRIORITY_EN
    task automatic test_priority();
        int            cycles;
        logic [DW-1:0] e;
        wait_ready(cycles);
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL prio_wait_ready got=%b exp=1 after %0d cycles", wr_ready, cycles); end
        wr_en = 1'b1; wr_addr = AW'(7);
        wr_data = 16'h8001; tick();
        wr_data = 16'h4002; tick();
        wr_data = 16'hC003; tick();
        wr_en = 1'b0;
        m_back[7] = 16'h4002;
        tick();
        wr_line_done = 1'b1; rd_line_start = 1'b1; tick();
        wr_line_done = 1'b0; rd_line_start = 1'b0;
        model_swap();
        issue_read(AW'(7), m_front[7]);
        e = exp_q.pop_front();
        n_checks++; if (rd_data !== e) begin n_fail++; $display("FAIL prio_addr7 got=%h exp=%h", rd_data, e); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_swap();
        test_underrun();
        test_same_cycle_swap();
        test_out_of_range();
`ifdef LINEBUF_PRIORITY_EN
        test_priority();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
